simple_cpu: RTL and testbench

//  Single-cycle 8-bit processor core with an 8x8 register file and a 6-instruction ISA.

---
 rtl/simple_cpu_if.sv | 9 +
 rtl/simple_cpu.sv | 101 ++++++++++
 tb/tb_simple_cpu.sv | 110 +++++++++++
 3 files changed

// File: rtl/simple_cpu_if.sv
// Instruction-fetch bus between the CPU core and an external instruction memory.
// The core drives the byte address; the memory returns the 32-bit word at that address.
interface simple_cpu_if;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;

  modport master (output PC, input INSTRUCTION);
  modport slave  (input PC, output INSTRUCTION);
endinterface

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit core: fetch/decode/execute in one cycle, regfile write and PC+4 at the edge.
// Holds its own control decode, ALU and an 8x8 register file (instance my_reg).
module simple_cpu_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [2:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [2:0] raddr_a_i,
  input  logic [2:0] raddr_b_i,
  output logic [7:0] rdata_a_o,
  output logic [7:0] rdata_b_o
);
  logic [7:0] REGISTER [0:7];

  // NOTE: the storage array is reset as a whole because a reset must clear every register at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) REGISTER[i] <= 8'h00;
    end else if (we_i) begin
      REGISTER[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = REGISTER[raddr_a_i];
  assign rdata_b_o = REGISTER[raddr_b_i];
endmodule

module simple_cpu (
  input  logic          CLK,
  input  logic          RESET,
  simple_cpu_if.master  imem
);
  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05
  } opcode_e;

  logic [31:0] pc_q, pc_d;
  logic [7:0]  opcode;
  logic [2:0]  rd_idx, rt_idx, rs_idx;
  logic [7:0]  imm;
  logic [7:0]  rt_val, rs_val;
  logic [7:0]  neg_rs, add_b, sum;
  logic [7:0]  result;
  logic        reg_we;
  logic        unused_fields;

  assign opcode = imem.INSTRUCTION[31:24];
  assign rd_idx = imem.INSTRUCTION[18:16];
  assign rt_idx = imem.INSTRUCTION[10:8];
  assign rs_idx = imem.INSTRUCTION[2:0];
  assign imm    = imem.INSTRUCTION[7:0];
  assign unused_fields = ^{imem.INSTRUCTION[23:19], imem.INSTRUCTION[15:11]};

  simple_cpu_regfile my_reg (
    .clk       (CLK),
    .rst       (RESET),
    .we_i      (reg_we),
    .waddr_i   (rd_idx),
    .wdata_i   (result),
    .raddr_a_i (rt_idx),
    .raddr_b_i (rs_idx),
    .rdata_a_o (rt_val),
    .rdata_b_o (rs_val)
  );

  // Subtraction reuses the adder with a two's-complement negated second operand.
  assign neg_rs = ~rs_val + 8'd1;
  assign add_b  = (opcode == OP_SUB) ? neg_rs : rs_val;
  assign sum    = rt_val + add_b;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    result = 8'h00;
    reg_we = 1'b0;
    case (opcode)
      OP_LOADI: begin result = imm;             reg_we = 1'b1; end
      OP_MOV:   begin result = rs_val;          reg_we = 1'b1; end
      OP_ADD,
      OP_SUB:   begin result = sum;             reg_we = 1'b1; end
      OP_AND:   begin result = rt_val & rs_val; reg_we = 1'b1; end
      OP_OR:    begin result = rt_val | rs_val; reg_we = 1'b1; end
      default:  begin result = 8'h00;           reg_we = 1'b0; end
    endcase
  end

  assign pc_d = pc_q + 32'd4;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pc_q <= 32'h0;
    else       pc_q <= pc_d;
  end

  assign imem.PC = pc_q;
endmodule

// File: tb/tb_simple_cpu.sv
// Directed bench for simple_cpu: runs a small program from a byte-wide instruction memory
// and checks PC and register contents after each committed instruction.
module tb_simple_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] mem [0:255];
  int n_asserts = 0;
  int n_fails   = 0;

  simple_cpu_if imem ();

  simple_cpu dut (
    .CLK   (clk),
    .RESET (rst),
    .imem  (imem.master)
  );

  always #4 clk = ~clk;

  assign imem.INSTRUCTION = {mem[imem.PC[7:0] + 8'd3], mem[imem.PC[7:0] + 8'd2],
                             mem[imem.PC[7:0] + 8'd1], mem[imem.PC[7:0]]};

  task automatic load_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[7:0];
    mem[addr + 1] = w[15:8];
    mem[addr + 2] = w[23:16];
    mem[addr + 3] = w[31:24];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    check($sformatf("r%0d", idx), {24'h0, dut.my_reg.REGISTER[idx]}, {24'h0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), {24'h0, dut.my_reg.REGISTER[i]}, 32'h0);
  endtask

  // Advance one instruction: commit at the rising edge, observe at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    load_word(0,  32'h00040005);  // loadi r4,5
    load_word(4,  32'h00020009);  // loadi r2,9
    load_word(8,  32'h02060402);  // add r6,r4,r2
    load_word(12, 32'h03010204);  // sub r1,r2,r4
    load_word(16, 32'h03000402);  // sub r0,r4,r2
    load_word(20, 32'h04030402);  // and r3,r4,r2
    load_word(24, 32'h05050402);  // or  r5,r4,r2
    load_word(28, 32'h01070006);  // mov r7,r6
    load_word(32, 32'h000100FF);  // loadi r1,0xFF
    load_word(36, 32'h02010101);  // add r1,r1,r1
    load_word(40, 32'h07010203);  // undefined opcode

    #1 rst = 1'b1;
    #2;
    check("reset_pc", imem.PC, 32'h0);
    check_all_zero("reset");
    #2;  // edge at t=4 happened with reset held
    check("reset_hold_pc", imem.PC, 32'h0);
    check_reg(4, 8'h00);
    rst = 1'b0;

    step(); check("pc_after_i0", imem.PC, 32'd4);  check_reg(4, 8'd5);
    step(); check("pc_after_i1", imem.PC, 32'd8);  check_reg(2, 8'd9);
    step(); check("pc_after_i2", imem.PC, 32'd12); check_reg(6, 8'd14);
    step(); check_reg(1, 8'd4);
    step(); check_reg(0, 8'hFC);
    step(); check_reg(3, 8'd1);
    step(); check_reg(5, 8'd13);
    step(); check_reg(7, 8'd14); check("pc_after_mov", imem.PC, 32'd32);
    step(); check_reg(1, 8'hFF);
    step(); check_reg(1, 8'hFE);
    step();
    check("pc_after_undef", imem.PC, 32'd44);
    check_reg(0, 8'hFC); check_reg(1, 8'hFE); check_reg(2, 8'd9); check_reg(3, 8'd1);
    check_reg(4, 8'd5);  check_reg(5, 8'd13); check_reg(6, 8'd14); check_reg(7, 8'd14);
    step(); check("pc_fill_word", imem.PC, 32'd48);

    // Asynchronous reset in the middle of a cycle
    #1 rst = 1'b1;
    #1;
    check("midrun_reset_pc", imem.PC, 32'h0);
    check_all_zero("midrun");
    step();
    check("midrun_hold_pc", imem.PC, 32'h0);
    check_reg(4, 8'h00);
    rst = 1'b0;

    step(); check("rerun_pc4", imem.PC, 32'd4); check_reg(4, 8'd5); check_reg(2, 8'd0);
    step(); check("rerun_pc8", imem.PC, 32'd8); check_reg(2, 8'd9); check_reg(6, 8'd0);
    step(); check("rerun_pc12", imem.PC, 32'd12); check_reg(6, 8'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
